// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between the IF (read) and MEM (read/write) ports.
// Optional IF anti-starvation streak limit is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 19,
  parameter int LATENCY        = 2,
  parameter int MAX_MEM_STREAK = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  output logic              o_if_stall,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_mem_stall,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a port raises req with stable addr/we/wdata and holds it until its
  // one-cycle ready pulse; on the edge ending that pulse it either drops req or
  // presents the next request, which is then arbitrated as new.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (LATENCY < 1 || MAX_MEM_STREAK < 1) begin : g_bad_params
    $error("mem_port_arbiter: LATENCY and MAX_MEM_STREAK must be >= 1");
  end

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;      // 1 = MEM owns the current access
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_mem_hold;
  logic              w_any_req;
  logic              w_grant_mem;
  logic              w_grant;

  assign w_any_req = i_if_req | i_mem_req;
  assign w_grant   = (r_state == S_IDLE) && w_any_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_MEM_STREAK + 1);
  logic [SW-1:0] r_streak;
  logic          w_force_if;

  // After MAX_MEM_STREAK MEM wins against a waiting IF, IF takes the next slot.
  assign w_force_if  = i_if_req && (r_streak == SW'(MAX_MEM_STREAK));
  assign w_grant_mem = i_mem_req && !w_force_if;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_streak <= '0;
    end else if (w_grant) begin
      r_streak <= (w_grant_mem && i_if_req) ? r_streak + SW'(1) : '0;
    end
  end
`else
  assign w_grant_mem = i_mem_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = (LATENCY == 1) ? S_DONE : S_WAIT;
      S_WAIT:  if (r_cnt <= CNT_W'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_hold  <= '0;
      r_mem_hold <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_mem;
        r_we    <= w_grant_mem & i_mem_we;
        r_addr  <= w_grant_mem ? i_mem_addr : i_if_addr;
        r_wdata <= w_grant_mem ? i_mem_wdata : '0;
      end
      if (r_state == S_ISSUE) r_cnt <= CNT_W'(LATENCY - 1);
      else if (r_state == S_WAIT) r_cnt <= r_cnt - CNT_W'(1);
      // Only a completing read refreshes the owner's hold register.
      if (r_state == S_DONE && !r_we) begin
        if (r_owner) r_mem_hold <= i_ram_rdata;
        else         r_if_hold  <= i_ram_rdata;
      end
    end
  end

  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_if_ready  = 1'b0;
    o_mem_ready = 1'b0;
    o_if_rdata  = r_if_hold;
    o_mem_rdata = r_mem_hold;
    case (r_state)
      S_ISSUE: begin
        o_ram_en = 1'b1;
        o_ram_we = r_we;
      end
      S_DONE: begin
        if (r_owner) o_mem_ready = 1'b1;
        else         o_if_ready  = 1'b1;
        if (!r_we) begin
          if (r_owner) o_mem_rdata = i_ram_rdata;
          else         o_if_rdata  = i_ram_rdata;
        end
      end
      default: ;
    endcase
    o_if_stall  = i_if_req & ~o_if_ready;
    o_mem_stall = i_mem_req & ~o_mem_ready;
  end

  assign o_ram_addr  = r_addr;
  assign o_ram_wdata = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed sequences, a vector table, a randomized slot-level model,
// and a LATENCY=1 instance.
module tb_mem_port_arbiter;
  localparam int AW   = 12;
  localparam int DW   = 19;
  localparam int LAT  = 2;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr, ram_addr;
  logic [DW-1:0] mem_wdata, if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic          if_ready, if_stall, mem_ready, mem_stall, ram_en, ram_we;
  logic [1:0]    dbg_state;

  logic          t1_if_req;
  logic [AW-1:0] t1_if_addr, t1_ram_addr;
  logic [DW-1:0] t1_if_rdata, t1_mem_rdata, t1_ram_wdata, t1_ram_rdata;
  logic          t1_if_ready, t1_if_stall, t1_mem_ready, t1_mem_stall, t1_ram_en, t1_ram_we;
  logic [1:0]    t1_dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .MAX_MEM_STREAK(MAXS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
    .o_if_ready(if_ready), .o_if_stall(if_stall),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready), .o_mem_stall(mem_stall),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata), .o_dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .MAX_MEM_STREAK(MAXS)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(t1_if_req), .i_if_addr(t1_if_addr), .o_if_rdata(t1_if_rdata),
    .o_if_ready(t1_if_ready), .o_if_stall(t1_if_stall),
    .i_mem_req(1'b0), .i_mem_we(1'b0), .i_mem_addr('0), .i_mem_wdata('0),
    .o_mem_rdata(t1_mem_rdata), .o_mem_ready(t1_mem_ready), .o_mem_stall(t1_mem_stall),
    .o_ram_en(t1_ram_en), .o_ram_we(t1_ram_we), .o_ram_addr(t1_ram_addr), .o_ram_wdata(t1_ram_wdata),
    .i_ram_rdata(t1_ram_rdata), .o_dbg_state(t1_dbg_state)
  );

  // ---------------- memory models ----------------
  logic [DW-1:0] ram [0:4095];
  logic          en_s, we_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s, junk;
  logic [DW-1:0] pipe_d [LAT];
  logic          pipe_v [LAT];

  always @(negedge clk) begin
    en_s = ram_en; we_s = ram_we; addr_s = ram_addr; wdata_s = ram_wdata;
  end

  always @(posedge clk) begin
    junk <= DW'($urandom);
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) pipe_v[k] <= 1'b0;
    end else begin
      if (en_s && we_s) ram[addr_s] = wdata_s;
      pipe_d[0] <= ram[addr_s];
      pipe_v[0] <= en_s && !we_s;
      for (int k = 1; k < LAT; k++) begin
        pipe_d[k] <= pipe_d[k-1];
        pipe_v[k] <= pipe_v[k-1];
      end
    end
  end
  assign ram_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : junk;

  function automatic logic [DW-1:0] f1(input logic [AW-1:0] a);
    return {a[6:0], a};
  endfunction

  logic          en1_s, v1;
  logic [AW-1:0] addr1_s;
  logic [DW-1:0] d1, junk1;
  always @(negedge clk) begin
    en1_s = t1_ram_en; addr1_s = t1_ram_addr;
  end
  always @(posedge clk) begin
    junk1 <= DW'($urandom);
    v1    <= rst_n && en1_s;
    d1    <= f1(addr1_s);
  end
  assign t1_ram_rdata = v1 ? d1 : junk1;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Issues one access from an idle arbiter; returns data seen with ready and cycles to ready.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output logic [DW-1:0] rdata, output int lat);
    bit got;
    got = 0;
    lat = 0;
    rdata = '0;
    if_req = !port; if_addr = addr;
    mem_req = port; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    for (int n = 0; n < 20; n++) begin
      mid();
      if ((port && mem_ready) || (!port && if_ready)) begin
        got = 1;
        rdata = port ? mem_rdata : if_rdata;
        break;
      end
      step();
      lat++;
    end
    if (!got) chk("access_timeout", 32'd0, 32'd1);
    step();
    if_req = 0; mem_req = 0; mem_we = 0;
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  // random-phase driver/model state
  bit            saw_if, saw_mem, g_valid, g_port, g_we, exp_en, exp_ir, exp_mr, g_mem;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata, hold_if, hold_mem, e;
  logic [DW-1:0] ref_mem [0:4095];
  int            g_cycle, free_at, streak;

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(4064, 4095));
  endfunction

  initial begin
    logic [DW-1:0] rd;
    int lat, n_g;
    int got_g [6];
    int exp_g [6];

    tbl[0] = '{1'b1, 1'b1, 12'hFFF, 19'h7FFFF, 19'h0BEEF};
    tbl[1] = '{1'b0, 1'b0, 12'hFFF, 19'h00000, 19'h7FFFF};
    tbl[2] = '{1'b1, 1'b1, 12'h000, 19'h12345, 19'h0BEEF};
    tbl[3] = '{1'b1, 1'b0, 12'h000, 19'h00000, 19'h12345};
    tbl[4] = '{1'b0, 1'b0, 12'h000, 19'h00000, 19'h12345};
    tbl[5] = '{1'b1, 1'b1, 12'h800, 19'h00001, 19'h12345};
    tbl[6] = '{1'b1, 1'b0, 12'h800, 19'h00000, 19'h00001};
    tbl[7] = '{1'b0, 1'b0, 12'h7FF, 19'h00000, 19'h2AAAA};

    for (int i = 0; i < 4096; i++) ram[i] = DW'(i * 7 + 3);
    ram[12'h010] = 19'h1ABCD;
    ram[12'h020] = 19'h0BEEF;
    ram[12'h030] = 19'h0CAFE;
    ram[12'h7FF] = 19'h2AAAA;

    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    t1_if_req = 0; t1_if_addr = '0;

    // reset state
    rst_n = 0;
    step(); step();
    mid();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_ram_addr", ram_addr, 0);
    step();
    rst_n = 1;

    // single IF read
    step();
    if_req = 1; if_addr = 12'h010;
    mid(); chk("t2_stall_c0", if_stall, 1); chk("t2_en_c0", ram_en, 0);
    step(); mid(); chk("t2_en_c1", ram_en, 1); chk("t2_addr_c1", ram_addr, 12'h010); chk("t2_we_c1", ram_we, 0);
    step(); mid(); chk("t2_ready_c2", if_ready, 0);
    step(); mid(); chk("t2_ready_c3", if_ready, 1); chk("t2_rdata_c3", if_rdata, 19'h1ABCD);
    chk("t2_stall_c3", if_stall, 0);
    step(); if_req = 0;
    mid(); chk("t2_ready_c4", if_ready, 0); chk("t2_hold_c4", if_rdata, 19'h1ABCD);

    // simultaneous requests: MEM first
    step();
    if_req = 1; if_addr = 12'h030; mem_req = 1; mem_we = 0; mem_addr = 12'h020;
    for (int cyc = 0; cyc < 8; cyc++) begin
      mid();
      chk($sformatf("t3_if_stall_c%0d", cyc), if_stall, 32'(cyc < 7));
      chk($sformatf("t3_mem_ready_c%0d", cyc), mem_ready, 32'(cyc == 3));
      chk($sformatf("t3_if_ready_c%0d", cyc), if_ready, 32'(cyc == 7));
      if (cyc == 1) chk("t3_addr_mem", ram_addr, 12'h020);
      if (cyc == 5) begin chk("t3_en_if", ram_en, 1); chk("t3_addr_if", ram_addr, 12'h030); end
      if (cyc == 3) chk("t3_mem_rdata", mem_rdata, 19'h0BEEF);
      if (cyc == 7) chk("t3_if_rdata", if_rdata, 19'h0CAFE);
      step();
      if (cyc == 3) mem_req = 0;
      if (cyc == 7) if_req = 0;
    end

    // MEM write
    mem_req = 1; mem_we = 1; mem_addr = 12'h020; mem_wdata = 19'h00055;
    for (int cyc = 0; cyc < 4; cyc++) begin
      mid();
      if (cyc == 1) begin
        chk("t4_en", ram_en, 1); chk("t4_we", ram_we, 1);
        chk("t4_addr", ram_addr, 12'h020); chk("t4_wdata", ram_wdata, 19'h00055);
      end
      chk($sformatf("t4_ready_c%0d", cyc), mem_ready, 32'(cyc == 3));
      if (cyc == 3) chk("t4_mem_rdata", mem_rdata, 19'h0BEEF);
      step();
      if (cyc == 3) begin mem_req = 0; mem_we = 0; end
    end
    do_access(1'b0, 1'b0, 12'h020, '0, rd, lat);
    chk("t4_readback", rd, 19'h00055);

    // vector table
    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      chk($sformatf("tbl%0d_lat", i), lat, LAT + 1);
    end

    // both held high: grant order (1 = MEM, 0 = IF)
`ifdef ARB_STARVE_GUARD_EN
    exp_g = '{1, 1, 0, 1, 1, 0};
`else
    exp_g = '{1, 1, 1, 1, 1, 1};
`endif
    got_g = '{2, 2, 2, 2, 2, 2};
    n_g = 0;
    if_req = 1; if_addr = 12'h041; mem_req = 1; mem_we = 0; mem_addr = 12'h040;
    for (int n = 0; n < 40 && n_g < 6; n++) begin
      mid();
      if (mem_ready) begin got_g[n_g] = 1; n_g++; end
      else if (if_ready) begin got_g[n_g] = 0; n_g++; end
      step();
    end
    if_req = 0; mem_req = 0;
    for (int k = 0; k < 6; k++) chk($sformatf("t5_grant%0d", k), got_g[k], exp_g[k]);

    // asynchronous reset during WAIT
    if_req = 1; if_addr = 12'h010;
    step(); step();
    rst_n = 0; #1;
    chk("t1_rst_en", ram_en, 0);
    chk("t1_rst_if_ready", if_ready, 0);
    chk("t1_rst_mem_ready", mem_ready, 0);
    chk("t1_rst_if_rdata", if_rdata, 0);
    chk("t1_rst_mem_rdata", mem_rdata, 0);
    step(); rst_n = 1;
    mid(); chk("t1_idle_en", ram_en, 0); chk("t1_idle_stall", if_stall, 1);
    step(); mid(); chk("t1_reissue_en", ram_en, 1); chk("t1_reissue_addr", ram_addr, 12'h010);
    step(); mid();
    step(); mid(); chk("t1_reissue_ready", if_ready, 1); chk("t1_reissue_rdata", if_rdata, 19'h1ABCD);
    step(); if_req = 0;

    // randomized run against a slot-level model
    rst_n = 0; step(); step(); rst_n = 1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
    saw_if = 0; saw_mem = 0; g_valid = 0; g_cycle = 0; free_at = 0; streak = 0;
    g_port = 0; g_we = 0; g_addr = '0; g_wdata = '0;
    hold_if = '0; hold_mem = '0;
    for (int c = 0; c < 1500; c++) begin
      if (saw_if) if_req = $urandom_range(0, 1) == 1;
      else if (!if_req) if_req = $urandom_range(0, 3) == 0;
      if (saw_if || !if_req) if_addr = rnd_addr();
      if (saw_mem) mem_req = $urandom_range(0, 1) == 1;
      else if (!mem_req) mem_req = $urandom_range(0, 2) == 0;
      if (saw_mem || !mem_req) begin
        mem_we = $urandom_range(0, 1) == 1; mem_addr = rnd_addr(); mem_wdata = DW'($urandom);
      end
      mid();
      exp_en = g_valid && (c == g_cycle + 1);
      exp_ir = g_valid && (c == g_cycle + LAT + 1) && !g_port;
      exp_mr = g_valid && (c == g_cycle + LAT + 1) && g_port;
      chk("r_ram_en", ram_en, exp_en);
      if (exp_en) begin
        chk("r_ram_addr", ram_addr, g_addr);
        chk("r_ram_we", ram_we, g_we);
        if (g_we) chk("r_ram_wdata", ram_wdata, g_wdata);
      end
      chk("r_if_ready", if_ready, exp_ir);
      chk("r_mem_ready", mem_ready, exp_mr);
      chk("r_if_stall", if_stall, if_req & ~exp_ir);
      chk("r_mem_stall", mem_stall, mem_req & ~exp_mr);
      if ((exp_ir || (exp_mr && !g_we)) && exp_q.size() == 0) chk("r_sb_empty", 0, 1);
      else if (exp_ir) begin e = exp_q.pop_front(); hold_if = e; end
      else if (exp_mr && !g_we) begin e = exp_q.pop_front(); hold_mem = e; end
      chk("r_if_rdata", if_rdata, hold_if);
      chk("r_mem_rdata", mem_rdata, hold_mem);
      saw_if = exp_ir; saw_mem = exp_mr;
      if (c >= free_at && (if_req || mem_req)) begin
        g_mem = mem_req;
`ifdef ARB_STARVE_GUARD_EN
        if (if_req && streak == MAXS) g_mem = 0;
        streak = (g_mem && if_req) ? streak + 1 : 0;
`endif
        g_valid = 1; g_cycle = c; free_at = c + LAT + 2;
        g_port = g_mem; g_we = g_mem && mem_we;
        g_addr = g_mem ? mem_addr : if_addr; g_wdata = mem_wdata;
        if (g_we) ref_mem[g_addr] = g_wdata;
        else exp_q.push_back(ref_mem[g_addr]);
      end
      step();
    end
    if_req = 0; mem_req = 0;

    // LATENCY=1 instance: no WAIT, one access every 3 cycles
    t1_if_req = 1; t1_if_addr = 12'h005;
    for (int cyc = 0; cyc < 9; cyc++) begin
      mid();
      chk($sformatf("t6_en_c%0d", cyc), t1_ram_en, 32'(cyc % 3 == 1));
      chk($sformatf("t6_ready_c%0d", cyc), t1_if_ready, 32'(cyc % 3 == 2));
      if (cyc % 3 == 1) chk("t6_addr", t1_ram_addr, t1_if_addr);
      if (cyc % 3 == 2) chk("t6_rdata", t1_if_rdata, f1(t1_if_addr));
      step();
      if (cyc % 3 == 2) t1_if_addr = t1_if_addr + 12'd1;
    end
    t1_if_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
